lsu_mem_stage: RTL and testbench

Load/store unit directly downstream of the ALU in the execute path. It takes the ALU's 32-bit result as the effective address for LB/LH/LW/LBU/LHU/SB/SH/SW, performs one word-aligned data-memory access over a req/gnt/rvalid bus, and returns the extracted, sign/zero-extended load data to writeback. It handles one outstanding access at a time.

---
 rtl/lsu_mem_stage.sv | 259 +++++++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit placed directly after the ALU in the execute path.
// It takes the ALU result as the effective address and runs one word-aligned access
// over a req/gnt/rvalid data bus. Only one access is outstanding at a time. Load data
// is extracted from the returned word and sign- or zero-extended for writeback.
//
// Build option LSU_MISALIGN_TRAP_EN:
//   - defined: misaligned H/W requests are rejected with a misalign_o pulse.
//   - undefined: the offending low address bits are ignored and the access proceeds.

module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    // Execute-stage request
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    input  logic        req_store_i,
    input  logic [4:0]  req_rd_i,

    // Data-memory bus
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    // Writeback and status
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic        misalign_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e          state_q;
    logic            req_ready_q;
    logic            mem_req_q;
    logic [31:0]     mem_addr_q;
    logic            mem_we_q;
    logic [3:0]      mem_be_q;
    logic [31:0]     mem_wdata_q;
    logic            store_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_q;
    logic [CntW-1:0] cnt_q;
    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic [31:0]     wb_data_q;
    logic            illegal_q;
    logic            timeout_q;

    // Decoded view of the incoming request
    logic            req_legal;
    logic            req_trap;
    logic [1:0]      req_off;
    logic [3:0]      req_be;
    logic [31:0]     req_wdata_rep;

    // Load extraction from the returned word
    logic [31:0]     rdata_shifted;
    logic [31:0]     load_data;

    logic            accept;

    assign accept = req_valid_i && req_ready_q;

    // Decode funct3 into legality, access offset, byte enables and replicated store data.
    // funct3[1:0] is the size code (00 byte, 01 half, 10 word) for every legal encoding.
    always_comb begin
        req_legal     = 1'b0;
        req_off       = req_addr_i[1:0];
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata_i;

        case (req_funct3_i)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_store_i;
            default:                req_legal = 1'b0;
        endcase

        case (req_funct3_i[1:0])
            2'b00: begin
                req_be        = 4'b0001 << req_off;
                req_wdata_rep = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                // Halfword accesses always start on an even byte lane
                req_off[0]    = 1'b0;
                req_be        = 4'b0011 << req_off;
                req_wdata_rep = {2{req_wdata_i[15:0]}};
            end
            default: begin
                req_off       = 2'b00;
                req_be        = 4'b1111;
                req_wdata_rep = req_wdata_i;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    assign req_trap = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                      (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
    assign misalign_o = misalign_q;

    // Pulse the misalignment trap the cycle after a misaligned request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && req_legal && req_trap;
        end
    end
`else
    assign req_trap   = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // Align the returned word to the access offset and extend to 32 bits.
    always_comb begin
        rdata_shifted = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_data = {24'h000000, rdata_shifted[7:0]};
            3'b101:  load_data = {16'h0000, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    // Access sequencer: request capture, bus handshake, response/timeout, status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            store_q     <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (!req_legal) begin
                            illegal_q <= 1'b1;
                        end else if (!req_trap) begin
                            state_q     <= StReq;
                            req_ready_q <= 1'b0;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {req_addr_i[31:2], 2'b00};
                            mem_we_q    <= req_store_i;
                            mem_be_q    <= req_be;
                            mem_wdata_q <= req_wdata_rep;
                            store_q     <= req_store_i;
                            funct3_q    <= req_funct3_i;
                            off_q       <= req_off;
                            rd_q        <= req_rd_i;
                        end
                    end
                end

                StReq: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        if (store_q) begin
                            state_q     <= StIdle;
                            req_ready_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= '0;
                        end
                    end
                end

                StWait: begin
                    if (mem_rvalid_i) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        // x0 loads still touch the bus but never write back
                        if (rd_q != 5'd0) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= load_data;
                        end
                    end else if (TIMEOUT_CYCLES != 0 &&
                                 cnt_q == CntW'(TIMEOUT_CYCLES)) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        timeout_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    mem_req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign illegal_o   = illegal_q;
    assign timeout_o   = timeout_q;

    // Bus request attributes may not move while waiting for the grant.
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        mem_req_o && !mem_gnt_i |=> mem_req_o && $stable(mem_addr_o) && $stable(mem_be_o)
                                    && $stable(mem_we_o) && $stable(mem_wdata_o));

    // Ready and an outstanding bus request are mutually exclusive.
    a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_ready_o && mem_req_o));

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized self-checking bench for lsu_mem_stage. Expected values come from a
// byte-level model of the load/store rules; timing is checked cycle by cycle.

module tb_lsu_mem_stage;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_funct3_i;
    logic        req_store_i;
    logic [4:0]  req_rd_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        illegal_o;
    logic        timeout_o;
    logic        misalign_o;

    int n_cmp = 0;
    int n_err = 0;

    // Last value the writeback port is expected to hold
    logic [4:0]  last_rd;
    logic [31:0] last_data;

    lsu_mem_stage #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_funct3_i(req_funct3_i),
        .req_store_i (req_store_i),
        .req_rd_i    (req_rd_i),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .wb_valid_o  (wb_valid_o),
        .wb_rd_o     (wb_rd_o),
        .wb_data_o   (wb_data_o),
        .illegal_o   (illegal_o),
        .timeout_o   (timeout_o),
        .misalign_o  (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One complete operation, starting and ending on a falling edge with the LSU idle.
    // rv_dly counts WAIT cycles before rvalid; beyond TO the load times out.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int gnt_dly,
                         input int rv_dly, input logic [31:0] rdata);
        bit          lg;
        bit          tr;
        int          sz;
        int          a;
        int          off;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
        logic [31:0] mask;

        lg = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz = 1 << f3[1:0];
        a  = int'(addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        tr = (a % sz) != 0;
`else
        tr = 1'b0;
`endif

        check_eq("ready_before", 32'(req_ready_o), 32'd1);
        req_valid_i  = 1'b1;
        req_store_i  = st;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        req_rd_i     = rd;
        @(negedge clk);
        req_valid_i  = 1'b0;
        req_addr_i   = $urandom;
        req_wdata_i  = $urandom;

        if (!lg) begin
            check_eq("illegal_pulse", 32'(illegal_o), 32'd1);
            check_eq("illegal_noreq", 32'(mem_req_o), 32'd0);
            @(negedge clk);
            check_eq("illegal_clear", 32'(illegal_o), 32'd0);
            check_eq("illegal_ready", 32'(req_ready_o), 32'd1);
            return;
        end
        if (tr) begin
            check_eq("misalign_pulse", 32'(misalign_o), 32'd1);
            check_eq("misalign_noreq", 32'(mem_req_o), 32'd0);
            @(negedge clk);
            check_eq("misalign_clear", 32'(misalign_o), 32'd0);
            check_eq("misalign_ready", 32'(req_ready_o), 32'd1);
            return;
        end
        check_eq("no_illegal", 32'(illegal_o), 32'd0);
        check_eq("no_misalign", 32'(misalign_o), 32'd0);

        // Expected bus view from the byte-lane rules
        off    = a - (a % sz);
        exp_be = 4'((32'd1 << sz) - 1) << off;
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % sz) +: 8];

        for (int i = 0; i <= gnt_dly; i++) begin
            check_eq("mem_req", 32'(mem_req_o), 32'd1);
            check_eq("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
            check_eq("mem_we", 32'(mem_we_o), 32'(st));
            check_eq("mem_be", 32'(mem_be_o), 32'(exp_be));
            if (st) check_eq("mem_wdata", mem_wdata_o, exp_wd);
            mem_gnt_i = (i == gnt_dly);
            @(negedge clk);
        end
        mem_gnt_i = 1'b0;
        check_eq("req_dropped", 32'(mem_req_o), 32'd0);

        if (st) begin
            check_eq("store_ready", 32'(req_ready_o), 32'd1);
            check_eq("store_no_wb", 32'(wb_valid_o), 32'd0);
            return;
        end
        check_eq("load_busy", 32'(req_ready_o), 32'd0);

        exp_ld = rdata >> (8 * off);
        if (sz < 4) begin
            mask   = (32'd1 << (8 * sz)) - 32'd1;
            exp_ld = exp_ld & mask;
            if (!f3[2] && exp_ld[8*sz-1]) exp_ld = exp_ld | ~mask;
        end

        for (int k = 0; k <= TO; k++) begin
            mem_rvalid_i = (k == rv_dly);
            mem_rdata_i  = (k == rv_dly) ? rdata : $urandom;
            mem_gnt_i    = 1'($urandom);
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_gnt_i    = 1'b0;
            if (k == rv_dly) begin
                check_eq("wb_valid", 32'(wb_valid_o), 32'(rd != 5'd0));
                if (rd != 5'd0) begin
                    last_rd   = rd;
                    last_data = exp_ld;
                end
                check_eq("wb_rd", 32'(wb_rd_o), 32'(last_rd));
                check_eq("wb_data", wb_data_o, last_data);
                check_eq("load_no_to", 32'(timeout_o), 32'd0);
                check_eq("load_ready", 32'(req_ready_o), 32'd1);
                @(negedge clk);
                check_eq("wb_one_pulse", 32'(wb_valid_o), 32'd0);
                return;
            end
            if (k == TO) begin
                check_eq("timeout_pulse", 32'(timeout_o), 32'd1);
                check_eq("timeout_no_wb", 32'(wb_valid_o), 32'd0);
                check_eq("timeout_ready", 32'(req_ready_o), 32'd1);
                check_eq("timeout_hold", wb_data_o, last_data);
                // A late response must be dropped
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = $urandom;
                @(negedge clk);
                mem_rvalid_i = 1'b0;
                check_eq("late_rvalid_no_wb", 32'(wb_valid_o), 32'd0);
                check_eq("timeout_clear", 32'(timeout_o), 32'd0);
                return;
            end
            check_eq("wait_no_to", 32'(timeout_o), 32'd0);
            check_eq("wait_no_wb", 32'(wb_valid_o), 32'd0);
            check_eq("wait_no_req", 32'(mem_req_o), 32'd0);
        end
    endtask

    // Issue a legal word load and stop after it has been accepted (LSU in REQ).
    task automatic start_lw(input logic [31:0] addr);
        req_valid_i  = 1'b1;
        req_store_i  = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = addr;
        req_rd_i     = 5'd9;
        @(negedge clk);
        req_valid_i  = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        req_funct3_i = '0;
        req_store_i  = 1'b0;
        req_rd_i     = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        last_rd      = '0;
        last_data    = '0;

        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(req_ready_o), 32'd1);
        check_eq("rst_mem_req", 32'(mem_req_o), 32'd0);
        check_eq("rst_mem_addr", mem_addr_o, 32'd0);
        check_eq("rst_mem_be", 32'(mem_be_o), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check_eq("rst_wb_data", wb_data_o, 32'd0);
        check_eq("rst_status", 32'({illegal_o, timeout_o, misalign_o}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd0, 0, 0, 32'h0);
        do_op(1'b0, 3'b000, 32'h0000_2001, 32'h0, 5'd5, 0, 0, 32'h1234_80FF);
        do_op(1'b0, 3'b100, 32'h0000_2001, 32'h0, 5'd5, 0, 0, 32'h1234_80FF);
        do_op(1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd6, 0, 0, 32'h8001_0000);
        do_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd6, 0, 0, 32'h8001_0000);
        do_op(1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd7, 3, 1, 32'h8001_0000);
        do_op(1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd8, 0, 0, 32'hDEAD_BEEF);
        do_op(1'b0, 3'b011, 32'h0000_3000, 32'h0, 5'd8, 0, 0, 32'h0);
        do_op(1'b1, 3'b100, 32'h0000_3000, 32'h0, 5'd8, 0, 0, 32'h0);
        do_op(1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd10, 0, 99, 32'h0);
        do_op(1'b0, 3'b010, 32'h0000_4004, 32'h0, 5'd0, 1, 2, 32'h1111_2222);
        do_op(1'b1, 3'b001, 32'h0000_5002, 32'h0000_BEEF, 5'd0, 2, 0, 32'h0);

        // Reset while the bus request is outstanding
        start_lw(32'h0000_6000);
        check_eq("req_before_rst", 32'(mem_req_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_req_async", 32'(mem_req_o), 32'd0);
        check_eq("rst_ready_async", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        last_rd   = '0;
        last_data = '0;
        check_eq("rst_wb_cleared", wb_data_o, 32'd0);

        // Reset while waiting for read data, then a stale response
        start_lw(32'h0000_6004);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        check_eq("wait_not_ready", 32'(req_ready_o), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_wait_ready", 32'(req_ready_o), 32'd1);
        check_eq("rst_wait_req", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        check_eq("stale_rvalid_no_wb", 32'(wb_valid_o), 32'd0);
        @(negedge clk);
        check_eq("stale_rvalid_no_wb2", 32'(wb_valid_o), 32'd0);
        check_eq("stale_ready", 32'(req_ready_o), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            do_op(1'($urandom), 3'($urandom), $urandom, $urandom, rd,
                  $urandom_range(0, 3), $urandom_range(0, 6), $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
